// File: rtl/mtf_pkg.sv
// Shared move-to-front definitions: list geometry, token kinds and the
// list-update rule used by both the decoder and encoder-side checkers.
package mtf_pkg;

  localparam int MTF_DEPTH = 4;
  localparam int MTF_IDX_W = 2;

  localparam logic TOK_LITERAL = 1'b0;
  localparam logic TOK_INDEX   = 1'b1;

  typedef logic [MTF_DEPTH-1:0] mtf_mask_t;
  typedef logic [MTF_IDX_W-1:0] mtf_idx_t;

  // Entries that reload on an update: entry 0 takes the new value and entry i
  // takes entry i-1. A hit at pos moves only 0..pos; a miss shifts everything.
  function automatic mtf_mask_t mtf_load_mask(input logic hit, input mtf_idx_t pos);
    mtf_mask_t mask;
    for (int i = 0; i < MTF_DEPTH; i++) begin
      mask[i] = !hit || (i <= int'(pos));
    end
    return mask;
  endfunction

endpackage

// File: rtl/mtf_decoder_if.sv
// Token-in / data-out handshake bundle of the move-to-front decoder.
interface mtf_decoder_if #(
  parameter int DATA_W = 8
);

  logic                            tok_valid;
  logic                            tok_ready;
  logic                            tok_is_index;
  logic [mtf_pkg::MTF_IDX_W-1:0]   tok_index;
  logic [DATA_W-1:0]               tok_literal;
  logic [DATA_W-1:0]               data;
  logic                            data_valid;
  logic                            data_ready;
  logic                            err;

  modport master (
    output tok_valid, tok_is_index, tok_index, tok_literal, data_ready,
    input  tok_ready, data, data_valid, err
  );

  modport slave (
    input  tok_valid, tok_is_index, tok_index, tok_literal, data_ready,
    output tok_ready, data, data_valid, err
  );

endinterface

// File: rtl/mtf_out_fifo.sv
// Two-entry output FIFO; the head entry is presented on data_out.
module mtf_out_fifo #(
  parameter int DATA_W = 8
) (
  input  logic              clk_in,
  input  logic              reset_n_in,
  input  logic              push_in,
  input  logic [DATA_W-1:0] push_data_in,
  input  logic              pop_in,
  output logic [DATA_W-1:0] data_out,
  output logic [1:0]        count_out,
  output logic              full_out,
  output logic              empty_out
);

  logic [DATA_W-1:0] r_mem [2];
  logic              r_wr_ptr;
  logic              r_rd_ptr;
  logic [1:0]        r_count;
  logic              w_do_push;
  logic              w_do_pop;

  assign w_do_pop  = pop_in  && (r_count != 2'd0);
  assign w_do_push = push_in && (r_count != 2'd2);

  // NOTE: both slots are reset so data_out reads zero out of reset; cheap at this depth.
  always_ff @(posedge clk_in or negedge reset_n_in) begin
    if (!reset_n_in) begin
      r_mem[0] <= '0;
      r_mem[1] <= '0;
      r_wr_ptr <= 1'b0;
      r_rd_ptr <= 1'b0;
      r_count  <= 2'd0;
    end else begin
      if (w_do_push) r_mem[r_wr_ptr] <= push_data_in;
      r_wr_ptr <= r_wr_ptr ^ w_do_push;
      r_rd_ptr <= r_rd_ptr ^ w_do_pop;
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + 2'd1;
        2'b01:   r_count <= r_count - 2'd1;
        default: r_count <= r_count;
      endcase
    end
  end

  assign data_out  = r_mem[r_rd_ptr];
  assign count_out = r_count;
  assign full_out  = (r_count == 2'd2);
  assign empty_out = (r_count == 2'd0);

endmodule

// File: rtl/mtf_decoder.sv
// Move-to-front token decoder: rebuilds the byte stream from literal/index
// tokens and keeps the 4-entry recency list in step with the encoder.
module mtf_decoder
  import mtf_pkg::*;
#(
  parameter int DATA_W = 8
) (
  input  logic                 clk_in,
  input  logic                 reset_n_in,
  input  logic                 tok_valid_in,
  output logic                 tok_ready_out,
  input  logic                 tok_is_index_in,
  input  logic [MTF_IDX_W-1:0] tok_index_in,
  input  logic [DATA_W-1:0]    tok_literal_in,
  output logic [DATA_W-1:0]    data_out,
  output logic                 data_valid_out,
  input  logic                 data_ready_in,
  output logic                 err_out,
  output logic [DATA_W-1:0]    list_0,
  output logic [DATA_W-1:0]    list_1,
  output logic [DATA_W-1:0]    list_2,
  output logic [DATA_W-1:0]    list_3,
  output logic                 list_valid_0,
  output logic                 list_valid_1,
  output logic                 list_valid_2,
  output logic                 list_valid_3
);

  logic [DATA_W-1:0]    r_list [MTF_DEPTH];
  logic [MTF_DEPTH-1:0] r_valid;
  logic                 r_rdy_en;
  logic                 r_err;

  logic [MTF_DEPTH-1:0] w_lit_match;
  mtf_idx_t             w_lit_pos;
  logic                 w_is_index;
  logic                 w_idx_ok;
  logic                 w_hit;
  mtf_idx_t             w_pos;
  logic [DATA_W-1:0]    w_value;
  logic                 w_accept;
  logic                 w_push;
  logic                 w_pop;
  logic                 w_err;
  mtf_mask_t            w_load;
  logic [1:0]           w_count;
  logic                 w_full;
  logic                 w_empty;

  // Valid entries hold distinct values, so at most one literal comparator fires.
  always_comb begin
    w_lit_match = '0;
    w_lit_pos   = '0;
    for (int i = 0; i < MTF_DEPTH; i++) begin
      w_lit_match[i] = r_valid[i] && (r_list[i] == tok_literal_in);
    end
    for (int i = MTF_DEPTH - 1; i >= 0; i--) begin
      if (w_lit_match[i]) w_lit_pos = mtf_idx_t'(i);
    end
  end

  assign w_is_index = (tok_is_index_in == TOK_INDEX);
  assign w_idx_ok   = r_valid[tok_index_in];
  assign w_value    = w_is_index ? r_list[tok_index_in] : tok_literal_in;
  assign w_hit      = w_is_index || (|w_lit_match);
  assign w_pos      = w_is_index ? tok_index_in : w_lit_pos;

  assign w_accept = tok_valid_in && tok_ready_out;
  assign w_push   = w_accept && (!w_is_index || w_idx_ok);
  assign w_err    = w_accept && w_is_index && !w_idx_ok;
  assign w_pop    = data_valid_out && data_ready_in;
  assign w_load   = w_push ? mtf_load_mask(w_hit, w_pos) : '0;

  // NOTE: non-blocking assignments let every entry read its neighbour's old value.
  always_ff @(posedge clk_in or negedge reset_n_in) begin
    if (!reset_n_in) begin
      for (int i = 0; i < MTF_DEPTH; i++) r_list[i] <= '0;
      r_valid <= '0;
    end else begin
      if (w_load[0]) begin
        r_list[0]  <= w_value;
        r_valid[0] <= 1'b1;
      end
      for (int i = 1; i < MTF_DEPTH; i++) begin
        if (w_load[i]) begin
          r_list[i]  <= r_list[i-1];
          r_valid[i] <= r_valid[i-1];
        end
      end
    end
  end

  // rdy_en holds off token acceptance until the first edge after reset release.
  always_ff @(posedge clk_in or negedge reset_n_in) begin
    if (!reset_n_in) begin
      r_rdy_en <= 1'b0;
      r_err    <= 1'b0;
    end else begin
      r_rdy_en <= 1'b1;
      r_err    <= w_err;
    end
  end

  mtf_out_fifo #(.DATA_W(DATA_W)) u_out_fifo (
    .clk_in       (clk_in),
    .reset_n_in   (reset_n_in),
    .push_in      (w_push),
    .push_data_in (w_value),
    .pop_in       (w_pop),
    .data_out     (data_out),
    .count_out    (w_count),
    .full_out     (w_full),
    .empty_out    (w_empty)
  );

  assign tok_ready_out  = r_rdy_en && (w_count < 2'd2);
  assign data_valid_out = !w_empty;
  assign err_out        = r_err;

  assign list_0       = r_list[0];
  assign list_1       = r_list[1];
  assign list_2       = r_list[2];
  assign list_3       = r_list[3];
  assign list_valid_0 = r_valid[0];
  assign list_valid_1 = r_valid[1];
  assign list_valid_2 = r_valid[2];
  assign list_valid_3 = r_valid[3];

  a_no_overflow: assert property (@(posedge clk_in) disable iff (!reset_n_in) !(w_push && w_full));

endmodule

// File: doc/mtf_decoder.md
# mtf_decoder

Move-to-front token decoder: the receive-side counterpart of `test_module`, which tracks the four most-recent distinct values of a byte stream. The block accepts a stream of tokens, each either a literal value or an index into a 4-entry recency list. It rebuilds the original data stream and keeps the same recency list, updated with identical move-to-front rules, so a bench can cross-check it against `test_module`. Both ends use valid/ready handshakes, and a 2-entry output buffer sustains one token per cycle.

## Interface
- `DATA_W`, 8: width of a data value.
- `clk_in`  in  1  clock, rising edge.
- `reset_n_in`  in  1  reset, asynchronous, active-low.
- `tok_valid_in`  in  1  token present.
- `tok_ready_out`  out  1  decoder can accept a token.
- `tok_is_index_in`  in  1  1 = index token, 0 = literal token.
- `tok_index_in`  in  2  list position 0..3 (index tokens only).
- `tok_literal_in`  in  DATA_W  literal value (literal tokens only).
- `data_out`  out  DATA_W  decoded value at the head of the output buffer.
- `data_valid_out`  out  1  `data_out` is valid.
- `data_ready_in`  in  1  consumer takes `data_out`.
- `err_out`  out  1  one-cycle pulse: index token pointed at an empty slot.
- `list_0..list_3`  out  DATA_W each  recency list; entry 0 is the most recent.
- `list_valid_0..list_valid_3`  out  1 each  list entry holds a value.

## Operation
- Clock and reset: single clock `clk_in`; reset is asynchronous and active-low on `reset_n_in`.
- A token is accepted on a rising edge where `tok_valid_in & tok_ready_out` is true.
- **Literal token, value V:**
  - If V matches a valid entry k, entries 0..k-1 shift down by one and V goes to entry 0.
  - Otherwise all entries shift down, entry 3 is dropped, V goes to entry 0 and `list_valid_0` is set.
  - V is pushed to the output buffer.
- **Index token k, `list_valid_k` = 1:** V = `list_k`. Entries 0..k-1 shift down and V goes to entry 0. V is pushed. Index 0 leaves the list unchanged.
- **Index token k, `list_valid_k` = 0:** the token is consumed, nothing is pushed, the list is unchanged, and `err_out` pulses for one cycle.
- Valid entries always occupy a contiguous run starting at 0. Values in valid entries are always distinct.
- **Output buffer:** 2-entry FIFO.
  - `data_valid_out` = buffer not empty.
  - Pop on `data_valid_out & data_ready_in`.
  - A push and a pop on the same edge leave the count unchanged.
- `tok_ready_out` = (buffer count < 2) & `rdy_en`. `rdy_en` is a flop cleared by reset and set on the first edge after reset release. `tok_ready_out` never depends combinationally on `data_ready_in`.

## Timing
- **Reset values:** all list entries are 0 and invalid. `data_out`, `data_valid_out`, `err_out` and `tok_ready_out` are all 0. The buffer is empty.
- **Reset release:** `tok_ready_out` rises after the first edge following release. The first token can be accepted on the second edge.
- **Latency:** a token accepted at edge N, with the buffer empty, appears on `data_out` with `data_valid_out` = 1 in the cycle after N. The list outputs also update after edge N.
- **Error timing:** `err_out` is high for exactly the cycle after the accepting edge.
- **Throughput:** one token per cycle while `data_ready_in` stays high; the buffer count stays at 1 or less.
- **Back-pressure:** with `data_ready_in` = 0, two tokens are accepted, then `tok_ready_out` = 0. It returns to 1 in the cycle after the first pop.
- **Data ordering:** `data_out` is held stable while `data_valid_out & ~data_ready_in`. No value is lost or duplicated.
- **Reset mid-stream:** the list, buffer and handshake return immediately to their reset values. Tokens in flight and buffered data are discarded.

## Structure
- Shared package `mtf_pkg`:
  - `MTF_DEPTH` = 4 and `MTF_IDX_W` = 2.
  - Token kind constants `TOK_LITERAL` = 0 and `TOK_INDEX` = 1.
  - The common list-update function, so encoder-side checkers can reuse it.
- Sub-module `mtf_out_fifo`: 2-entry FIFO (push/pop, count, full, empty), parameterised by `DATA_W`.
- Top level contains: the list registers, the match/compare logic, the shift logic and the `rdy_en` flop.

## Test plan
- **Reset:** hold `reset_n_in` low for 3 cycles while driving `tok_valid_in` = 1. Require all outputs 0, no token accepted, and `tok_ready_out` = 1 only after the first edge following release.
- **Full-throughput sequence:** tokens L1 L2 L3 L4 I1 I2 I1 I2 I1 I1 with `data_ready_in` = 1. Require `data_out` = 1 2 3 4 3 2 3 4 3 4 on consecutive cycles and a final list of 4,3,2,1 with all entries valid.
- **Empty-slot index:** after L7 only, send I2. Require `err_out` pulse, no push, list = 7,-,-,-. Then I0 gives `data_out` = 7.
- **Literal hits and eviction:** L5 L5 L9 L5 gives list 5,9; then L1 L2 L3 gives list 3,2,1,5 with 9 evicted. Repeated literals must never create duplicate entries.
- **Back-pressure:** hold `data_ready_in` = 0 and offer L10 L11 L12. Require exactly two tokens accepted and `tok_ready_out` = 0. Releasing `data_ready_in` gives 10, 11, 12 in order.
- **Random cross-check:** 100000 random bytes go into `test_module`. Convert its lists to tokens (index on a hit, literal otherwise) and feed them to the decoder with random `data_ready_in`. Require a decoded stream equal to the input and lists equal to `test_module` outputs. Include a reset mid-stream.
